// File: rtl/dcmac_0_axis_pkt_gen_buffer_ctx_mc_if.sv
// Request/response bundle for the per-ID byte-buffer context tracker.
// The master modport issues requests and flushes; the slave modport returns registered responses.
interface dcmac_0_axis_pkt_gen_buffer_ctx_mc_if #(
  parameter int ID_W   = 3,
  parameter int SIZE_W = 8
);
  logic              i_valid;
  logic [ID_W-1:0]   i_id;
  logic [SIZE_W-1:0] i_size;
  logic              i_flush;
  logic [ID_W-1:0]   i_flush_id;
  logic              o_valid;
  logic [ID_W-1:0]   o_id;
  logic [SIZE_W-1:0] o_buf_size;
  logic [SIZE_W-1:0] o_buf_idx;
  logic              o_dat_req;
  logic              o_err;

  modport master (
    output i_valid, i_id, i_size, i_flush, i_flush_id,
    input  o_valid, o_id, o_buf_size, o_buf_idx, o_dat_req, o_err
  );

  modport slave (
    input  i_valid, i_id, i_size, i_flush, i_flush_id,
    output o_valid, o_id, o_buf_size, o_buf_idx, o_dat_req, o_err
  );
endinterface

// File: rtl/dcmac_0_axis_pkt_gen_buffer_ctx_mc.sv
// Per-ID byte-buffer context tracker: reports the pre-request (size, idx) of each stream's
// current data line, signals when a new line must be fetched, and supports flush and error rejection.
module dcmac_0_axis_pkt_gen_buffer_ctx_mc #(
  parameter int NUM_ID       = 8,
  parameter int ID_W         = 3,
  parameter int BUF_BYTES    = 192,
  parameter int SIZE_W       = 8,
  parameter int EAGER_REFILL = 0
) (
  input  logic clk,
  input  logic rst_n,
  dcmac_0_axis_pkt_gen_buffer_ctx_mc_if.slave bus
);
  // Table covers the full id space so any id indexes it safely; entries >= NUM_ID are never written.
  localparam int DEPTH = 1 << ID_W;
  localparam logic [SIZE_W:0] BUF_EXT = (SIZE_W+1)'(BUF_BYTES);

  logic [SIZE_W-1:0] ctx_size [DEPTH];
  logic [SIZE_W-1:0] ctx_idx  [DEPTH];

  // One extra bit of headroom keeps N - S and X + N exact before they are folded back into range.
  function automatic void next_ctx(
    input  logic [SIZE_W:0]   s,
    input  logic [SIZE_W:0]   x,
    input  logic [SIZE_W:0]   n,
    output logic              need,
    output logic [SIZE_W-1:0] s_nx,
    output logic [SIZE_W-1:0] x_nx
  );
    logic [SIZE_W:0] x_w;
    need = (n > s) || ((EAGER_REFILL != 0) && (n == s));
    s_nx = SIZE_W'(need ? (BUF_EXT - (n - s)) : (s - n));
    x_w  = need ? (n - s) : (x + n);
    x_nx = (x_w == BUF_EXT) ? '0 : SIZE_W'(x_w);
  endfunction

  logic              vld_p0;
  logic              id_ok_p0;
  logic              size_ok_p0;
  logic              ok_p0;
  logic              need_p0;
  logic              flush_ok_p0;
  logic [SIZE_W-1:0] s_p0;
  logic [SIZE_W-1:0] x_p0;
  logic [SIZE_W-1:0] s_nx_p0;
  logic [SIZE_W-1:0] x_nx_p0;

  // Stage p0: combinational context read and next-state computation.
  always_comb begin
    vld_p0      = bus.i_valid;
    id_ok_p0    = int'(bus.i_id) < NUM_ID;
    size_ok_p0  = (bus.i_size != '0) && ({1'b0, bus.i_size} <= BUF_EXT);
    ok_p0       = id_ok_p0 && size_ok_p0;
    flush_ok_p0 = bus.i_flush && (int'(bus.i_flush_id) < NUM_ID);
    s_p0        = ctx_size[bus.i_id];
    x_p0        = ctx_idx[bus.i_id];
    need_p0     = 1'b0;
    s_nx_p0     = '0;
    x_nx_p0     = '0;
    next_ctx({1'b0, s_p0}, {1'b0, x_p0}, {1'b0, bus.i_size}, need_p0, s_nx_p0, x_nx_p0);
  end

  // Stage p1: context write-back and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctx_size[i] <= '0;
        ctx_idx[i]  <= '0;
      end
      bus.o_valid    <= 1'b0;
      bus.o_id       <= '0;
      bus.o_buf_size <= '0;
      bus.o_buf_idx  <= '0;
      bus.o_dat_req  <= 1'b0;
      bus.o_err      <= 1'b0;
    end else begin
      if (vld_p0 && ok_p0) begin
        ctx_size[bus.i_id] <= s_nx_p0;
        ctx_idx[bus.i_id]  <= x_nx_p0;
      end
      // Issued after the request write so a same-id flush overrides the stored result.
      if (flush_ok_p0) begin
        ctx_size[bus.i_flush_id] <= '0;
        ctx_idx[bus.i_flush_id]  <= '0;
      end
      bus.o_valid    <= vld_p0;
      bus.o_id       <= vld_p0 ? bus.i_id : '0;
      bus.o_err      <= vld_p0 && !ok_p0;
      bus.o_dat_req  <= vld_p0 && ok_p0 && need_p0;
      bus.o_buf_size <= (vld_p0 && ok_p0) ? s_p0 : '0;
      bus.o_buf_idx  <= (vld_p0 && ok_p0) ? x_p0 : '0;
    end
  end
endmodule

// File: tb/tb_dcmac_0_axis_pkt_gen_buffer_ctx_mc.sv
// Bench for the buffer context tracker: three instances (default, eager refill, NUM_ID=9),
// directed scenarios plus randomized traffic checked against a lines-fetched / bytes-consumed model.
module tb_dcmac_0_axis_pkt_gen_buffer_ctx_mc;
  localparam int BUF = 192;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcmac_0_axis_pkt_gen_buffer_ctx_mc_if #(.ID_W(3), .SIZE_W(8)) bus_a ();
  dcmac_0_axis_pkt_gen_buffer_ctx_mc_if #(.ID_W(3), .SIZE_W(8)) bus_e ();
  dcmac_0_axis_pkt_gen_buffer_ctx_mc_if #(.ID_W(4), .SIZE_W(8)) bus_n ();

  dcmac_0_axis_pkt_gen_buffer_ctx_mc #(.NUM_ID(8), .ID_W(3), .BUF_BYTES(BUF), .SIZE_W(8), .EAGER_REFILL(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  dcmac_0_axis_pkt_gen_buffer_ctx_mc #(.NUM_ID(8), .ID_W(3), .BUF_BYTES(BUF), .SIZE_W(8), .EAGER_REFILL(1))
    dut_e (.clk(clk), .rst_n(rst_n), .bus(bus_e.slave));
  dcmac_0_axis_pkt_gen_buffer_ctx_mc #(.NUM_ID(9), .ID_W(4), .BUF_BYTES(BUF), .SIZE_W(8), .EAGER_REFILL(0))
    dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n.slave));

  int checks = 0;
  int errors = 0;

  // Model: a stream has fetched `lines` data lines and consumed `cons` bytes in total.
  int lines [3][16];
  int cons  [3][16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 16; j++) begin
        lines[i][j] = 0;
        cons[i][j]  = 0;
      end
  endtask

  function automatic void predict(input int inst, input int id, input int sz,
                                  output bit err, output bit need, output int s, output int x);
    int nid;
    nid  = (inst == 2) ? 9 : 8;
    err  = (sz == 0) || (sz > BUF) || (id >= nid);
    need = 1'b0;
    s    = 0;
    x    = 0;
    if (!err) begin
      s    = lines[inst][id] * BUF - cons[inst][id];
      x    = cons[inst][id] % BUF;
      need = (sz > s) || ((inst == 1) && (sz == s));
    end
  endfunction

  task automatic drive(input int inst, input bit v, input int id, input int sz, input bit fl, input int fid);
    case (inst)
      0: begin
        bus_a.i_valid = v; bus_a.i_id = 3'(id); bus_a.i_size = 8'(sz);
        bus_a.i_flush = fl; bus_a.i_flush_id = 3'(fid);
      end
      1: begin
        bus_e.i_valid = v; bus_e.i_id = 3'(id); bus_e.i_size = 8'(sz);
        bus_e.i_flush = fl; bus_e.i_flush_id = 3'(fid);
      end
      default: begin
        bus_n.i_valid = v; bus_n.i_id = 4'(id); bus_n.i_size = 8'(sz);
        bus_n.i_flush = fl; bus_n.i_flush_id = 4'(fid);
      end
    endcase
  endtask

  task automatic sample(input int inst, output logic [31:0] v, output logic [31:0] e,
                        output logic [31:0] r, output logic [31:0] s, output logic [31:0] x,
                        output logic [31:0] id);
    case (inst)
      0: begin
        v = 32'(bus_a.o_valid); e = 32'(bus_a.o_err); r = 32'(bus_a.o_dat_req);
        s = 32'(bus_a.o_buf_size); x = 32'(bus_a.o_buf_idx); id = 32'(bus_a.o_id);
      end
      1: begin
        v = 32'(bus_e.o_valid); e = 32'(bus_e.o_err); r = 32'(bus_e.o_dat_req);
        s = 32'(bus_e.o_buf_size); x = 32'(bus_e.o_buf_idx); id = 32'(bus_e.o_id);
      end
      default: begin
        v = 32'(bus_n.o_valid); e = 32'(bus_n.o_err); r = 32'(bus_n.o_dat_req);
        s = 32'(bus_n.o_buf_size); x = 32'(bus_n.o_buf_idx); id = 32'(bus_n.o_id);
      end
    endcase
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic check_zero(input string tag);
    logic [31:0] v, e, r, s, x, id;
    for (int i = 0; i < 3; i++) begin
      sample(i, v, e, r, s, x, id);
      chk($sformatf("%s%0d.valid", tag, i), v, 0);
      chk($sformatf("%s%0d.err", tag, i), e, 0);
      chk($sformatf("%s%0d.dat_req", tag, i), r, 0);
      chk($sformatf("%s%0d.size", tag, i), s, 0);
      chk($sformatf("%s%0d.idx", tag, i), x, 0);
      chk($sformatf("%s%0d.id", tag, i), id, 0);
    end
  endtask

  // One request cycle (optionally with a flush) on a single instance, checked one cycle later.
  task automatic req(input string tag, input int inst, input int id, input int sz,
                     input bit fl, input int fid);
    logic [31:0] v, e, r, s, x, oid;
    bit ee, er;
    int es, ex;
    predict(inst, id, sz, ee, er, es, ex);
    drive(inst, 1'b1, id, sz, fl, fid);
    @(posedge clk);
    #1;
    drive(inst, 1'b0, 0, 0, 1'b0, 0);
    sample(inst, v, e, r, s, x, oid);
    chk({tag, ".valid"}, v, 1);
    chk({tag, ".err"}, e, 32'(ee));
    chk({tag, ".dat_req"}, r, 32'(er));
    chk({tag, ".size"}, s, es);
    chk({tag, ".idx"}, x, ex);
    chk({tag, ".id"}, oid, id);
    if (!ee) begin
      if (er) lines[inst][id]++;
      cons[inst][id] += sz;
    end
    if (fl) begin
      lines[inst][fid] = 0;
      cons[inst][fid]  = 0;
    end
  endtask

  task automatic flush_only(input string tag, input int inst, input int fid);
    logic [31:0] v, e, r, s, x, oid;
    drive(inst, 1'b0, 0, 0, 1'b1, fid);
    @(posedge clk);
    #1;
    drive(inst, 1'b0, 0, 0, 1'b0, 0);
    sample(inst, v, e, r, s, x, oid);
    chk({tag, ".valid"}, v, 0);
    lines[inst][fid] = 0;
    cons[inst][fid]  = 0;
  endtask

  initial begin
    idle_all();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) req($sformatf("t1_id3_%0d", k), 0, 3, 64, 1'b0, 0);

    req("t2_a", 0, 0, 100, 1'b0, 0);
    req("t2_b", 0, 0, 100, 1'b0, 0);
    req("t2_c", 0, 0, 184, 1'b0, 0);

    for (int k = 0; k < 10; k++)
      req($sformatf("t3_%0d", k), 0, (k % 2 == 0) ? 1 : 2, (k % 2 == 0) ? 40 : 150, 1'b0, 0);

    req("t4_a", 0, 5, 64, 1'b0, 0);
    req("t4_b", 0, 5, 32, 1'b1, 5);
    req("t4_c", 0, 5, 10, 1'b0, 0);
    req("t4_d", 0, 6, 20, 1'b1, 7);

    for (int k = 0; k < 4; k++) req($sformatf("t5_%0d", k), 1, 2, 64, 1'b0, 0);

    req("t6_pre", 2, 0, 50, 1'b0, 0);
    req("t6_sz0", 2, 0, 0, 1'b0, 0);
    req("t6_sz200", 2, 0, 200, 1'b0, 0);
    req("t6_id9", 2, 9, 30, 1'b0, 0);
    req("t6_id8", 2, 8, 30, 1'b0, 0);
    req("t6_post", 2, 0, 50, 1'b0, 0);
    req("t6_edge192", 0, 4, 192, 1'b0, 0);
    req("t6_edge192b", 0, 4, 192, 1'b0, 0);

    flush_only("flush_idle", 0, 0);

    for (int k = 0; k < 400; k++) begin
      int inst, id, sz, fid;
      bit fl;
      inst = $urandom_range(0, 2);
      id   = (inst == 2) ? $urandom_range(0, 15) : $urandom_range(0, 7);
      fid  = (inst == 2) ? $urandom_range(0, 15) : $urandom_range(0, 7);
      case ($urandom_range(0, 9))
        0:       sz = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(193, 255);
        1, 2:    sz = $urandom_range(97, 192);
        default: sz = $urandom_range(1, 96);
      endcase
      fl = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 11) == 0) flush_only($sformatf("rnd_fl%0d", k), inst, fid);
      else req($sformatf("rnd%0d", k), inst, id, sz, fl, fid);
    end

    req("t7_a", 0, 3, 64, 1'b0, 0);
    req("t7_b", 0, 3, 64, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t7_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    req("t7_after", 0, 3, 64, 1'b0, 0);
    req("t7_after_e", 1, 2, 64, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
